// File: rtl/regfile_mport.sv
// Multi-read-port register file that zero-fills every word after reset.
// Writes take effect on the clock edge; read data is registered (1 cycle); busy is high while the clear runs.
module regfile_mport #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     addr_d,
  input  logic [DW-1:0]     data_in,
  input  logic              re,
  input  logic [NRD*AW-1:0] addr_r,
  output logic [NRD*DW-1:0] q,
  output logic              busy
);

  typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};

  state_t        r_state;
  logic [AW:0]   r_clr_cnt;
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q [NRD];
  logic          w_wr_en;
  logic [DW-1:0] w_rd_dat [NRD];

  assign w_wr_en = (r_state == ST_RUN) && we && !((ZERO_R0 != 0) && (addr_d == '0));
  assign busy    = (r_state == ST_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == LAST_ADDR)
        r_state <= ST_RUN;
    end
  end

  // Storage has no reset; the clear sequence is the only initialisation.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR)
      r_mem[r_clr_cnt[AW-1:0]] <= '0;
    else if (w_wr_en)
      r_mem[addr_d] <= data_in;
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      w_rd_dat[i] = r_mem[addr_r[i*AW +: AW]];
      if ((BYPASS != 0) && w_wr_en && (addr_d == addr_r[i*AW +: AW]))
        w_rd_dat[i] = data_in;
      if ((ZERO_R0 != 0) && (addr_r[i*AW +: AW] == '0))
        w_rd_dat[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NRD; i++) r_q[i] <= '0;
    end else if (r_state == ST_CLEAR) begin
      for (int i = 0; i < NRD; i++) r_q[i] <= '0;
    end else if (re) begin
      for (int i = 0; i < NRD; i++) r_q[i] <= w_rd_dat[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_q
      assign q[g*DW +: DW] = r_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mport.sv
// Directed bench: three AW=4 instances (bypass, no-bypass, zero-r0) share one stimulus.
module tb_regfile_mport;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NRD = 2;

  logic clk = 1'b0;
  logic rst, we, re;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_in;
  logic [NRD*AW-1:0] addr_r;
  logic [NRD*DW-1:0] q_a, q_b, q_z;
  logic busy_a, busy_b, busy_z;

  int n_vec = 0;
  int n_bad = 0;
  int nb;

  always #5 clk = ~clk;

  regfile_mport #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(1), .ZERO_R0(0)) u_dut_a (
    .clk(clk), .rst(rst), .we(we), .addr_d(addr_d), .data_in(data_in), .re(re),
    .addr_r(addr_r), .q(q_a), .busy(busy_a));
  regfile_mport #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(0), .ZERO_R0(0)) u_dut_b (
    .clk(clk), .rst(rst), .we(we), .addr_d(addr_d), .data_in(data_in), .re(re),
    .addr_r(addr_r), .q(q_b), .busy(busy_b));
  regfile_mport #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(1), .ZERO_R0(1)) u_dut_z (
    .clk(clk), .rst(rst), .we(we), .addr_d(addr_d), .data_in(data_in), .re(re),
    .addr_r(addr_r), .q(q_z), .busy(busy_z));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Counts negedge samples with busy high, bounded so a stuck FSM cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    we = 1'b0; re = 1'b1; addr_r = {a1, a0};
    step();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; re = 1'b0; addr_d = a; data_in = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; addr_d = '0; data_in = '0; addr_r = '0;
    step(); step();
    chk("rst_busy", {31'b0, busy_a}, 32'd1);
    chk("rst_q", q_a[31:0] | q_a[63:32], 32'h0);

    // Writes and reads attempted during CLEAR must be ignored.
    we = 1'b1; addr_d = 4'h3; data_in = 32'h0000_0055; re = 1'b1; addr_r = {4'h3, 4'h3};
    rst = 1'b0;
    count_busy(nb);
    chk("clr_cycles", nb, 32'd16);
    chk("clr_busy_b", {31'b0, busy_b}, 32'd0);
    chk("clr_q_held0", q_a[31:0], 32'h0);

    for (int i = 0; i < 16; i++) begin
      rd2(i[AW-1:0], i[AW-1:0]);
      chk($sformatf("init_rd%0d_p0", i), q_a[31:0], 32'h0);
      chk($sformatf("init_rd%0d_p1", i), q_a[63:32], 32'h0);
    end

    wr(4'h5, 32'hDEAD_BEEF);
    rd2(4'h5, 4'h6);
    chk("rd5_p0", q_a[31:0], 32'hDEAD_BEEF);
    chk("rd6_p1", q_a[63:32], 32'h0);

    // Same-cycle write and read to 0xA on both ports.
    we = 1'b1; addr_d = 4'hA; data_in = 32'h1234_5678; re = 1'b1; addr_r = {4'hA, 4'hA};
    step();
    we = 1'b0;
    chk("byp_a_p0", q_a[31:0], 32'h1234_5678);
    chk("byp_a_p1", q_a[63:32], 32'h1234_5678);
    chk("nobyp_b_p0", q_b[31:0], 32'h0);
    rd2(4'hA, 4'h5);
    chk("nobyp_b_later", q_b[31:0], 32'h1234_5678);
    chk("nobyp_b_p1", q_b[63:32], 32'hDEAD_BEEF);

    wr(4'h0, 32'hFFFF_FFFF);
    rd2(4'h0, 4'h0);
    chk("z_r0_p0", q_z[31:0], 32'h0);
    chk("z_r0_p1", q_z[63:32], 32'h0);
    chk("a_r0_p0", q_a[31:0], 32'hFFFF_FFFF);

    we = 1'b1; addr_d = 4'h0; data_in = 32'h1111_1111; re = 1'b1; addr_r = {4'h5, 4'h0};
    step();
    we = 1'b0;
    chk("z_r0_byp", q_z[31:0], 32'h0);
    chk("z_p1_rd5", q_z[63:32], 32'hDEAD_BEEF);
    chk("a_r0_byp", q_a[31:0], 32'h1111_1111);
    chk("b_r0_old", q_b[31:0], 32'hFFFF_FFFF);

    wr(4'h7, 32'hA5A5_A5A5);
    rd2(4'h7, 4'h7);
    chk("rd7", q_a[31:0], 32'hA5A5_A5A5);
    re = 1'b0; addr_r = {4'h5, 4'h5}; we = 1'b1; addr_d = 4'h7; data_in = 32'h0;
    step(); step();
    we = 1'b0;
    chk("hold_p0", q_a[31:0], 32'hA5A5_A5A5);
    chk("hold_p1", q_a[63:32], 32'hA5A5_A5A5);
    rd2(4'h3, 4'h7);
    chk("clr_ignored_we", q_a[31:0], 32'h0);
    chk("rd7_after_wr", q_a[63:32], 32'h0);

    wr(4'h5, 32'hCAFE_F00D);
    rst = 1'b1;
    #1;
    chk("run_rst_busy", {31'b0, busy_a}, 32'd1);
    chk("run_rst_q", q_a[31:0], 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_clr_busy", {31'b0, busy_a}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(nb);
    chk("mid_rst_cycles", nb, 32'd16);
    rd2(4'h5, 4'hA);
    chk("post_rst_rd5", q_a[31:0], 32'h0);
    chk("post_rst_rdA", q_a[63:32], 32'h0);
    rd2(4'h0, 4'hF);
    chk("post_rst_rd0", q_a[31:0], 32'h0);
    chk("post_rst_rdF", q_a[63:32], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
